coin_ternary_sampler: RTL

- Consumer of the 16-bit `coins` stream from the free-running coin LFSR in the Encaps datapath.
- Reduces each coin byte mod 3 to a ternary coefficient (HRSS sample_iid).
- Streams N coefficients, two per beat, over a valid/ready interface to the polynomial buffer; index N-1 is forced to 0.
- One start/busy/done run per polynomial.

---
 rtl/ntru_pkg.sv | 28 ++
 rtl/byte_mod3.sv | 11 +
 rtl/coin_ternary_sampler.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ntru_pkg.sv
// Shared NTRU/HRSS sampler definitions: default polynomial length, ternary
// coefficient encoding, byte mod-3 reduction and the sampler state type.
package ntru_pkg;

  localparam int unsigned N_DEFAULT = 701;

  localparam logic [1:0] COEF_ZERO = 2'b00;
  localparam logic [1:0] COEF_POS  = 2'b01;
  localparam logic [1:0] COEF_NEG  = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  // Residue 2 maps to -1, so 2'b11 can never be produced.
  function automatic logic [1:0] mod3(input logic [7:0] b);
    logic [1:0] r;
    r = 2'(b % 8'd3);
    case (r)
      2'd1:    return COEF_POS;
      2'd2:    return COEF_NEG;
      default: return COEF_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/byte_mod3.sv
// Combinational reduction of one coin byte to an encoded ternary coefficient.
module byte_mod3
  import ntru_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [1:0] coef_c
);

  assign coef_c = mod3(in_byte);

endmodule

// File: rtl/coin_ternary_sampler.sv
// Samples N ternary coefficients from the coin LFSR stream, two per beat,
// onto a valid/ready stream; coefficient N-1 is forced to zero.
module coin_ternary_sampler
  import ntru_pkg::*;
#(
  parameter  int unsigned N      = N_DEFAULT,
  localparam int unsigned BEATS  = (N + 1) / 2,
  localparam int unsigned BEAT_W = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       coins,
  output logic              busy,
  output logic              done,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic [3:0]        coef_data,
  output logic [1:0]        coef_mask,
  output logic              coef_last,
  output logic [BEAT_W-1:0] coef_beat
);

  state_e            state_q, state_d;
  logic [BEAT_W-1:0] cnt_q, cnt_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              valid_q, valid_d;
  logic [3:0]        data_q, data_d;
  logic [1:0]        mask_q, mask_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [1:0]  lane0_c, lane1_c;
  logic [1:0]  lane0_sel_c, lane1_sel_c;
  logic [1:0]  mask_sel_c;
  logic [31:0] idx0_c, idx1_c;
  logic        last_beat_c;

  byte_mod3 u_lane0 (.in_byte(coins[15:8]), .coef_c(lane0_c));
  byte_mod3 u_lane1 (.in_byte(coins[7:0]),  .coef_c(lane1_c));

  // Coefficient N-1 and anything past N read as zero; only indices >= N are masked off.
  always_comb begin
    idx0_c      = 32'({cnt_q, 1'b0});
    idx1_c      = idx0_c + 32'd1;
    lane0_sel_c = (idx0_c >= N - 1) ? COEF_ZERO : lane0_c;
    lane1_sel_c = (idx1_c >= N - 1) ? COEF_ZERO : lane1_c;
    mask_sel_c  = {idx1_c < N, idx0_c < N};
    last_beat_c = (cnt_q == BEAT_W'(BEATS - 1));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    valid_d = valid_q;
    data_d  = data_q;
    mask_d  = mask_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // Capture only into an empty or draining output register; stalled coins are dropped.
        if (!valid_q || coef_ready) begin
          data_d  = {lane1_sel_c, lane0_sel_c};
          mask_d  = mask_sel_c;
          beat_d  = cnt_q;
          cnt_d   = cnt_q + BEAT_W'(1);
          valid_d = 1'b1;
          last_d  = last_beat_c;
          if (last_beat_c) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (coef_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      mask_q  <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign coef_valid = valid_q;
  assign coef_data  = data_q;
  assign coef_mask  = mask_q;
  assign coef_last  = last_q;
  assign coef_beat  = beat_q;

endmodule
